// File: rtl/ram_pkg.sv
// Shared types and address-window helper for the dual-port bus RAM and the bus decoder.
package ram_pkg;

  localparam int ADDR_W = 30;

  typedef enum logic [0:0] {
    LAT1 = 1'b0,
    LAT2 = 1'b1
  } ram_latency_e;

  // True when the upper address bits match the base; the low 'bits' bits index the array.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int unsigned       bits);
    return (addr >> bits) == (base >> bits);
  endfunction

endpackage

// File: rtl/ram_port_pipe.sv
// One RAM port's control: valid/err stages, stall/ready, RAM enable and optional output register.
// Response LATENCY cycles after fire; a held response freezes every stage and drops req_ready.
module ram_port_pipe
  import ram_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_in_range,
  input  logic         req_write,
  output logic         ram_en,
  input  logic [W-1:0] ram_rd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err
);

  localparam ram_latency_e LAT = (LATENCY == 2) ? LAT2 : LAT1;

  logic         stall;
  logic         fire;
  logic         s1_vld_q, s1_vld_d;
  logic         s1_err_q, s1_err_d;
  logic         s1_rd_q, s1_rd_d;
  logic [W-1:0] s1_dat;
  logic         s2_vld_q, s2_vld_d;
  logic         s2_err_q, s2_err_d;
  logic [W-1:0] s2_dat_q, s2_dat_d;

  always_comb begin
    stall     = rsp_valid & ~rsp_ready;
    req_ready = ~stall;
    fire      = req_valid & ~stall;
    ram_en    = fire & req_in_range;
    // Writes and out-of-window requests answer with zero data.
    s1_dat    = s1_rd_q ? ram_rd_data : '0;

    s1_vld_d = s1_vld_q;
    s1_err_d = s1_err_q;
    s1_rd_d  = s1_rd_q;
    s2_vld_d = s2_vld_q;
    s2_err_d = s2_err_q;
    s2_dat_d = s2_dat_q;
    if (!stall) begin
      s1_vld_d = fire;
      s1_err_d = fire & ~req_in_range;
      s1_rd_d  = fire & req_in_range & ~req_write;
      s2_vld_d = s1_vld_q;
      s2_err_d = s1_err_q;
      s2_dat_d = s1_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_vld_q <= 1'b0;
      s1_err_q <= 1'b0;
      s1_rd_q  <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_err_q <= 1'b0;
      s2_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_err_q <= s1_err_d;
      s1_rd_q  <= s1_rd_d;
      s2_vld_q <= s2_vld_d;
      s2_err_q <= s2_err_d;
      s2_dat_q <= s2_dat_d;
    end
  end

  assign rsp_valid = (LAT == LAT2) ? s2_vld_q : s1_vld_q;
  assign rsp_err   = (LAT == LAT2) ? s2_err_q : s1_err_q;
  assign rsp_data  = (LAT == LAT2) ? s2_dat_q : s1_dat;

endmodule

// File: rtl/ram_dual.sv
// Two-port byte-maskable RAM: port A read-only, port B read/write, read-first on collision.
// Response 1 or 2 cycles after fire; each port stalls independently while its response is held.
module ram_dual
  import ram_pkg::*;
#(
  parameter int          SIZE    = 4096,
  parameter int          LANES   = 4,
  parameter int          LATENCY = 1,
  parameter logic [29:0] BASE    = 30'h0,
  parameter string       FILE    = "",
  localparam int         BITS    = $clog2(SIZE),
  localparam int         W       = 8 * LANES
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [29:0]      a_req_addr,
  output logic             a_rsp_valid,
  input  logic             a_rsp_ready,
  output logic [W-1:0]     a_rsp_data,
  output logic             a_rsp_err,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [29:0]      b_req_addr,
  input  logic [W-1:0]     b_req_data_w,
  input  logic [LANES-1:0] b_req_mask_w,
  output logic             b_rsp_valid,
  input  logic             b_rsp_ready,
  output logic [W-1:0]     b_rsp_data,
  output logic             b_rsp_err
);

  (* ram_style = "block" *) logic [W-1:0] mem [SIZE];

  logic [BITS-1:0]  a_idx, b_idx;
  logic             a_in, b_in;
  logic             a_en, b_en;
  logic             b_write;
  logic [LANES-1:0] b_we;
  logic [W-1:0]     a_ram_dat, b_ram_dat;

  always_comb begin
    a_idx   = a_req_addr[BITS-1:0];
    b_idx   = b_req_addr[BITS-1:0];
    a_in    = in_window(a_req_addr, BASE, BITS);
    b_in    = in_window(b_req_addr, BASE, BITS);
    b_write = |b_req_mask_w;
    b_we    = (b_en && b_write) ? b_req_mask_w : '0;
  end

  always_ff @(posedge clock) begin
    if (a_en) a_ram_dat <= mem[a_idx];
  end

  // Non-blocking read and lane writes give read-first behaviour on both ports.
  always_ff @(posedge clock) begin
    if (b_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (b_we[i]) mem[b_idx][8*i +: 8] <= b_req_data_w[8*i +: 8];
      end
      b_ram_dat <= mem[b_idx];
    end
  end

  ram_port_pipe #(.LATENCY(LATENCY), .W(W)) u_pipe_a (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (a_req_valid),
    .req_ready    (a_req_ready),
    .req_in_range (a_in),
    .req_write    (1'b0),
    .ram_en       (a_en),
    .ram_rd_data  (a_ram_dat),
    .rsp_valid    (a_rsp_valid),
    .rsp_ready    (a_rsp_ready),
    .rsp_data     (a_rsp_data),
    .rsp_err      (a_rsp_err)
  );

  ram_port_pipe #(.LATENCY(LATENCY), .W(W)) u_pipe_b (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (b_req_valid),
    .req_ready    (b_req_ready),
    .req_in_range (b_in),
    .req_write    (b_write),
    .ram_en       (b_en),
    .ram_rd_data  (b_ram_dat),
    .rsp_valid    (b_rsp_valid),
    .rsp_ready    (b_rsp_ready),
    .rsp_data     (b_rsp_data),
    .rsp_err      (b_rsp_err)
  );

endmodule

// File: tb/tb_ram_dual.sv
// Bench for ram_dual: one instance per latency, directed steps then random traffic against a word-array model.
module tb_ram_dual;

  localparam int          SIZE = 16;
  localparam logic [29:0] BASE = 30'h100;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
    int          s;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0]        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [1:0][29:0]  a_req_addr;
  logic [1:0][31:0]  a_rsp_data;
  logic [1:0]        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [1:0][29:0]  b_req_addr;
  logic [1:0][31:0]  b_req_data_w, b_rsp_data;
  logic [1:0][3:0]   b_req_mask_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_dual #(.SIZE(SIZE), .LANES(4), .LATENCY(g + 1), .BASE(BASE), .FILE("")) u_dut (
      .clock        (clk),
      .reset_n      (reset_n),
      .a_req_valid  (a_req_valid[g]),
      .a_req_ready  (a_req_ready[g]),
      .a_req_addr   (a_req_addr[g]),
      .a_rsp_valid  (a_rsp_valid[g]),
      .a_rsp_ready  (a_rsp_ready[g]),
      .a_rsp_data   (a_rsp_data[g]),
      .a_rsp_err    (a_rsp_err[g]),
      .b_req_valid  (b_req_valid[g]),
      .b_req_ready  (b_req_ready[g]),
      .b_req_addr   (b_req_addr[g]),
      .b_req_data_w (b_req_data_w[g]),
      .b_req_mask_w (b_req_mask_w[g]),
      .b_rsp_valid  (b_rsp_valid[g]),
      .b_rsp_ready  (b_rsp_ready[g]),
      .b_rsp_data   (b_rsp_data[g]),
      .b_rsp_err    (b_rsp_err[g])
    );
  end

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          cur = 0;
  int          ready_low = 0;
  logic [31:0] mem_m [SIZE];
  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] acc_a[$];
  bit          fa, fb;
  bit          held [2];
  logic [31:0] held_dat [2];
  logic        held_err [2];
  int          stalls [2];
  logic [31:0] last_dat [2];
  logic        last_err [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s (lat%0d): observed=%0h expected=%0h", tag, cur + 1, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [29:0] addr);
    return (32'(addr) >= 32'(BASE)) && (32'(addr) < 32'(BASE) + SIZE);
  endfunction

  // Response-side checks for one port at the sampling point of one cycle.
  task automatic mon(input int p, input logic vld, input logic rdy, input logic [31:0] dat,
                     input logic err, input logic qrdy);
    exp_t  e;
    logic  stall;
    int    sz;
    string pn;
    pn    = (p == 0) ? "a" : "b";
    stall = vld & ~rdy;
    chk({pn, "_req_ready"}, 32'(qrdy), 32'(!stall));
    if (p == 0 && !qrdy) ready_low++;
    if (held[p]) begin
      chk({pn, "_hold_valid"}, 32'(vld), 32'd1);
      chk({pn, "_hold_data"}, dat, held_dat[p]);
      chk({pn, "_hold_err"}, 32'(err), 32'(held_err[p]));
    end else if (vld) begin
      sz = (p == 0) ? qa.size() : qb.size();
      chk({pn, "_rsp_expected"}, 32'(sz != 0), 32'd1);
      if (sz != 0) begin
        if (p == 0) e = qa[0];
        else e = qb[0];
        chk({pn, "_rsp_data"}, dat, e.d);
        chk({pn, "_rsp_err"}, 32'(err), 32'(e.e));
        chk({pn, "_latency"}, 32'(cyc - e.c - (stalls[p] - e.s)), 32'(cur + 1));
      end
    end
    if (vld && rdy) begin
      last_dat[p] = dat;
      last_err[p] = err;
      if (p == 0) begin
        acc_a.push_back(dat);
        if (qa.size() != 0) void'(qa.pop_front());
      end else if (qb.size() != 0) begin
        void'(qb.pop_front());
      end
    end
    held[p]     = stall;
    held_dat[p] = dat;
    held_err[p] = err;
    if (stall) stalls[p]++;
  endtask

  // One clock: sample at negedge, update model on fires, return just after posedge.
  task automatic step();
    exp_t e;
    int   idx;
    @(negedge clk);
    fa = 0;
    fb = 0;
    mon(0, a_rsp_valid[cur], a_rsp_ready[cur], a_rsp_data[cur], a_rsp_err[cur], a_req_ready[cur]);
    mon(1, b_rsp_valid[cur], b_rsp_ready[cur], b_rsp_data[cur], b_rsp_err[cur], b_req_ready[cur]);
    if (a_req_valid[cur] && a_req_ready[cur]) begin
      fa  = 1;
      e.c = cyc;
      e.s = stalls[0];
      e.e = !in_win(a_req_addr[cur]);
      e.d = 32'h0;
      if (!e.e) begin
        idx = int'(a_req_addr[cur] - BASE);
        e.d = mem_m[idx];
      end
      qa.push_back(e);
    end
    if (b_req_valid[cur] && b_req_ready[cur]) begin
      fb  = 1;
      e.c = cyc;
      e.s = stalls[1];
      e.e = !in_win(b_req_addr[cur]);
      e.d = 32'h0;
      if (!e.e) begin
        idx = int'(b_req_addr[cur] - BASE);
        if (b_req_mask_w[cur] == 4'h0) e.d = mem_m[idx];
        for (int i = 0; i < 4; i++)
          if (b_req_mask_w[cur][i]) mem_m[idx][8*i +: 8] = b_req_data_w[cur][8*i +: 8];
      end
      qb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    a_req_valid = '0;
    b_req_valid = '0;
    reset_n     = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    reset_n = 1'b1;
    qa.delete();
    qb.delete();
    held = '{default: 0};
    @(negedge clk);
    chk("rst_a_valid", 32'(a_rsp_valid[cur]), 32'd0);
    chk("rst_b_valid", 32'(b_rsp_valid[cur]), 32'd0);
    chk("rst_a_ready", 32'(a_req_ready[cur]), 32'd1);
    chk("rst_b_ready", 32'(b_req_ready[cur]), 32'd1);
    chk("rst_a_err", 32'(a_rsp_err[cur]), 32'd0);
    chk("rst_b_err", 32'(b_rsp_err[cur]), 32'd0);
    if (cur == 1) begin
      chk("rst_a_data", a_rsp_data[cur], 32'd0);
      chk("rst_b_data", b_rsp_data[cur], 32'd0);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      step();
      n++;
    end
    chk("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  task automatic b_op(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] mask);
    int n = 0;
    b_req_valid[cur]  = 1'b1;
    b_req_addr[cur]   = addr;
    b_req_data_w[cur] = data;
    b_req_mask_w[cur] = mask;
    do begin
      step();
      n++;
    end while (!fb && n < 20);
    chk("b_fire", 32'(fb), 32'd1);
    b_req_valid[cur] = 1'b0;
  endtask

  task automatic a_rd(input logic [29:0] addr);
    int n = 0;
    a_req_valid[cur] = 1'b1;
    a_req_addr[cur]  = addr;
    do begin
      step();
      n++;
    end while (!fa && n < 20);
    chk("a_fire", 32'(fa), 32'd1);
    a_req_valid[cur] = 1'b0;
  endtask

  task automatic run_suite();
    logic [31:0] sd [8];
    int          nf;
    int          t;
    do_reset();
    for (int i = 0; i < SIZE; i++) b_op(30'(BASE + 30'(i)), $urandom, 4'hF);
    drain();

    b_op(BASE + 30'd5, 32'hDEADBEEF, 4'hF);
    drain();
    a_rd(BASE + 30'd5);
    drain();
    chk("t1_a_data", last_dat[0], 32'hDEADBEEF);
    chk("t1_a_err", 32'(last_err[0]), 32'd0);

    b_op(BASE + 30'd7, 32'hAABBCCDD, 4'hF);
    b_op(BASE + 30'd7, 32'h11223344, 4'b0101);
    drain();
    chk("t2_wack_data", last_dat[1], 32'd0);
    chk("t2_wack_err", 32'(last_err[1]), 32'd0);
    b_op(BASE + 30'd7, 32'h0, 4'h0);
    drain();
    chk("t2_masked_rd", last_dat[1], 32'hAA22CC44);

    b_op(BASE, 32'h0BADF00D, 4'hF);
    b_op(BASE + 30'(SIZE), 32'hFFFFFFFF, 4'hF);
    drain();
    chk("t3_oor_wr_data", last_dat[1], 32'd0);
    chk("t3_oor_wr_err", 32'(last_err[1]), 32'd1);
    b_op(BASE - 30'd1, 32'h0, 4'h0);
    drain();
    chk("t3_below_err", 32'(last_err[1]), 32'd1);
    a_rd(BASE);
    drain();
    chk("t3_base_kept", last_dat[0], 32'h0BADF00D);
    a_rd(BASE + 30'(SIZE));
    drain();
    chk("t3_a_oor_err", 32'(last_err[0]), 32'd1);
    chk("t3_a_oor_data", last_dat[0], 32'd0);

    b_op(BASE + 30'd3, 32'h1, 4'hF);
    drain();
    a_req_valid[cur]  = 1'b1;
    a_req_addr[cur]   = BASE + 30'd3;
    b_req_valid[cur]  = 1'b1;
    b_req_addr[cur]   = BASE + 30'd3;
    b_req_data_w[cur] = 32'h2;
    b_req_mask_w[cur] = 4'hF;
    step();
    chk("t4_both_fire", {30'd0, fa, fb}, 32'd3);
    a_req_valid[cur] = 1'b0;
    b_req_valid[cur] = 1'b0;
    drain();
    chk("t4_read_first", last_dat[0], 32'h1);
    a_rd(BASE + 30'd3);
    drain();
    chk("t4_new_data", last_dat[0], 32'h2);
    b_op(BASE + 30'd4, 32'hCAFE0004, 4'hF);
    b_op(BASE + 30'd4, 32'h0, 4'h0);
    drain();
    chk("t4_b_raw", last_dat[1], 32'hCAFE0004);

    for (int i = 0; i < 8; i++) begin
      sd[i] = $urandom;
      b_op(30'(BASE + 30'd8 + 30'(i)), sd[i], 4'hF);
    end
    drain();
    acc_a.delete();
    ready_low = 0;
    nf = 0;
    t  = 0;
    while ((nf < 8 || qa.size() != 0) && t < 60) begin
      a_req_valid[cur] = (nf < 8);
      a_req_addr[cur]  = 30'(BASE + 30'd8 + 30'(nf));
      a_rsp_ready[cur] = !(t >= 4 && t <= 6);
      step();
      if (fa) nf++;
      t++;
    end
    a_req_valid[cur] = 1'b0;
    a_rsp_ready[cur] = 1'b1;
    chk("t5_ready_low_cycles", 32'(ready_low), 32'd3);
    chk("t5_rsp_count", 32'(acc_a.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < acc_a.size()) chk($sformatf("t5_stream_%0d", i), acc_a[i], sd[i]);
    end

    a_req_valid[cur] = 1'b1;
    a_req_addr[cur]  = BASE + 30'd5;
    step();
    a_req_addr[cur]   = BASE + 30'd7;
    b_req_valid[cur]  = 1'b1;
    b_req_addr[cur]   = BASE + 30'd9;
    b_req_data_w[cur] = 32'h5A5AA5A5;
    b_req_mask_w[cur] = 4'hF;
    step();
    chk("t6_fires", {30'd0, fa, fb}, 32'd3);
    do_reset();
    for (int i = 0; i < 4; i++) step();
    a_rd(BASE + 30'd9);
    drain();
    chk("t6_write_kept", last_dat[0], 32'h5A5AA5A5);

    for (int i = 0; i < 300; i++) begin
      a_req_valid[cur]  = 1'($urandom_range(0, 1));
      a_req_addr[cur]   = 30'(BASE - 30'd2 + 30'($urandom_range(0, SIZE + 3)));
      b_req_valid[cur]  = 1'($urandom_range(0, 1));
      b_req_addr[cur]   = 30'(BASE - 30'd2 + 30'($urandom_range(0, SIZE + 3)));
      b_req_data_w[cur] = $urandom;
      b_req_mask_w[cur] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      a_rsp_ready[cur]  = ($urandom_range(0, 3) != 0);
      b_rsp_ready[cur]  = ($urandom_range(0, 3) != 0);
      step();
    end
    a_req_valid[cur] = 1'b0;
    b_req_valid[cur] = 1'b0;
    a_rsp_ready[cur] = 1'b1;
    b_rsp_ready[cur] = 1'b1;
    drain();
  endtask

  initial begin
    reset_n      = 1'b0;
    a_req_valid  = '0;
    a_req_addr   = '0;
    a_rsp_ready  = '1;
    b_req_valid  = '0;
    b_req_addr   = '0;
    b_req_data_w = '0;
    b_req_mask_w = '0;
    b_rsp_ready  = '1;
    held         = '{default: 0};
    stalls       = '{default: 0};
    for (int k = 0; k < 2; k++) begin
      cur = k;
      run_suite();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
